// File: rtl/sfx_sequencer.sv
// sfx_sequencer: event-driven sound-effect melody player feeding note_gen
// Ports:
//   i_clk, i_rst_n            audio-domain clock, asynchronous active-low reset
//   i_jump_tgl, i_land_tgl,
//   i_cd_tgl, i_over_tgl      toggle-encoded events from the pixel-clock domain
//   i_cd_code                 countdown value, travels alongside i_cd_tgl
//   i_mute                    silences o_note_div without stopping the sequence
//   o_note_div                note_gen divider, 1 = silence
//   o_active                  high while a sequence plays
//   o_cur_id                  current/last sequence: 0 JUMP, 1 LAND, 2 CD, 3 OVER
//   o_drop_cnt                saturating count of events lost to arbitration
module sfx_sequencer #(
    parameter int TICK_CYCLES = 5000000,
    parameter int DIV_W       = 22
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_jump_tgl,
    input  logic             i_land_tgl,
    input  logic             i_cd_tgl,
    input  logic [2:0]       i_cd_code,
    input  logic             i_over_tgl,
    input  logic             i_mute,
    output logic [DIV_W-1:0] o_note_div,
    output logic             o_active,
    output logic [1:0]       o_cur_id,
    output logic [7:0]       o_drop_cnt
);
    localparam int TW = $clog2(6 * TICK_CYCLES);
    localparam int C4 = 190839, D4 = 170068, E4 = 151515, A4 = 113636, B4 = 101214;

    typedef enum logic [1:0] {IDLE, PLAY, NEXT} state_t;
    typedef struct packed {
        logic [DIV_W-1:0] div;
        logic [2:0]       dur;
        logic             last;
    } step_t;

    function automatic step_t mk(input int div, input int dur, input logic last);
        mk.div  = DIV_W'(div);
        mk.dur  = 3'(dur);
        mk.last = last;
    endfunction

    function automatic step_t rom(input logic [1:0] id, input logic [1:0] code, input logic [1:0] step);
        case (id)
            2'd0:    rom = (step == 2'd0) ? mk(C4, 2, 1'b0) : mk(E4, 2, 1'b1);
            2'd1:    rom = mk(A4, 2, 1'b1);
            2'd2:    rom = (code == 2'd3) ? mk(C4, 3, 1'b1) :
                           (code == 2'd2) ? mk(D4, 3, 1'b1) :
                           (code == 2'd1) ? mk(E4, 3, 1'b1) : mk(B4, 6, 1'b1);
            default: rom = (step == 2'd0) ? mk(B4, 3, 1'b0) :
                           (step == 2'd1) ? mk(A4, 3, 1'b0) :
                           (step == 2'd2) ? mk(E4, 3, 1'b0) : mk(C4, 6, 1'b1);
        endcase
    endfunction

    state_t           r_state;
    logic [3:0]       r_s0, r_s1, r_prev, r_ev;
    logic [2:0]       r_code0, r_code1;
    logic [1:0]       r_code_ev, r_code, r_step, r_id;
    logic [TW-1:0]    r_timer;
    logic [DIV_W-1:0] r_note_div;
    logic             r_active;
    logic [7:0]       r_drop;

    logic [1:0] w_win;
    logic [2:0] w_hits, w_lost;
    logic       w_accept;
    logic [8:0] w_sum;
    step_t      w_new, w_cur, w_nxt;

    // Event bits are indexed by sequence id, so the highest set bit is the priority winner
    assign w_win    = r_ev[3] ? 2'd3 : r_ev[2] ? 2'd2 : r_ev[1] ? 2'd1 : 2'd0;
    assign w_hits   = 3'(r_ev[0]) + 3'(r_ev[1]) + 3'(r_ev[2]) + 3'(r_ev[3]);
    assign w_accept = (|r_ev) && (r_state == IDLE || w_win >= r_id);
    assign w_lost   = w_hits - 3'(w_accept);
    assign w_sum    = 9'(r_drop) + 9'(w_lost);
    assign w_new    = rom(w_win, r_code_ev, 2'd0);
    assign w_cur    = rom(r_id, r_code, r_step);
    assign w_nxt    = rom(r_id, r_code, r_step + 2'd1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_s0       <= '0;
            r_s1       <= '0;
            r_prev     <= '0;
            r_ev       <= '0;
            r_code0    <= '0;
            r_code1    <= '0;
            r_code_ev  <= '0;
            r_code     <= '0;
            r_step     <= '0;
            r_id       <= '0;
            r_timer    <= '0;
            r_note_div <= DIV_W'(1);
            r_active   <= 1'b0;
            r_drop     <= '0;
        end else begin
            r_s0    <= {i_over_tgl, i_cd_tgl, i_land_tgl, i_jump_tgl};
            r_s1    <= r_s0;
            r_prev  <= r_s1;
            r_code0 <= i_cd_code;
            r_code1 <= r_code0;
            // Countdown codes 4-7 are masked here so they never reach arbitration or the drop count
            r_ev    <= (r_s1 ^ r_prev) & {1'b1, ~r_code1[2], 2'b11};
            if (r_s1[2] ^ r_prev[2])
                r_code_ev <= r_code1[1:0];
            r_drop  <= w_sum[8] ? 8'hff : w_sum[7:0];
            if (w_accept) begin
                r_state    <= PLAY;
                r_id       <= w_win;
                r_code     <= r_code_ev;
                r_step     <= '0;
                r_timer    <= TW'(w_new.dur) * TW'(TICK_CYCLES) - TW'(1);
                r_active   <= 1'b1;
                r_note_div <= i_mute ? DIV_W'(1) : w_new.div;
            end else begin
                case (r_state)
                    PLAY: begin
                        r_note_div <= i_mute ? DIV_W'(1) : w_cur.div;
                        if (r_timer == '0)
                            r_state <= NEXT;
                        else
                            r_timer <= r_timer - TW'(1);
                    end
                    NEXT: begin
                        if (w_cur.last) begin
                            r_state    <= IDLE;
                            r_active   <= 1'b0;
                            r_note_div <= DIV_W'(1);
                        end else begin
                            r_state    <= PLAY;
                            r_step     <= r_step + 2'd1;
                            r_timer    <= TW'(w_nxt.dur) * TW'(TICK_CYCLES) - TW'(1);
                            r_note_div <= i_mute ? DIV_W'(1) : w_nxt.div;
                        end
                    end
                    default: begin
                        r_active   <= 1'b0;
                        r_note_div <= DIV_W'(1);
                    end
                endcase
            end
        end
    end

    assign o_note_div = r_note_div;
    assign o_active   = r_active;
    assign o_cur_id   = r_id;
    assign o_drop_cnt = r_drop;
endmodule

// File: tb/tb_sfx_sequencer.sv
// tb_sfx_sequencer: directed self-checking bench for sfx_sequencer
module tb_sfx_sequencer;
    localparam int TICK = 10;
    localparam int C4 = 190839, D4 = 170068, E4 = 151515, A4 = 113636, B4 = 101214;

    logic        clk = 1'b0, rst_n = 1'b0, mute = 1'b0;
    logic        jump_tgl = 1'b0, land_tgl = 1'b0, cd_tgl = 1'b0, over_tgl = 1'b0;
    logic [2:0]  cd_code = 3'd0;
    logic [21:0] note_div;
    logic        active;
    logic [1:0]  cur_id;
    logic [7:0]  drop_cnt;
    int          n_checks = 0, n_errors = 0;

    always #5 clk = ~clk;

    sfx_sequencer #(.TICK_CYCLES(TICK), .DIV_W(22)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_jump_tgl(jump_tgl), .i_land_tgl(land_tgl),
        .i_cd_tgl(cd_tgl), .i_cd_code(cd_code), .i_over_tgl(over_tgl), .i_mute(mute),
        .o_note_div(note_div), .o_active(active), .o_cur_id(cur_id), .o_drop_cnt(drop_cnt)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic play(input string tag, input int div, input int n);
        for (int i = 0; i < n; i++) begin
            step(1);
            chk(tag, int'(note_div), div);
            chk({tag, "_active"}, int'(active), 1);
        end
    endtask

    task automatic idle_end(input string tag);
        step(1);
        chk({tag, "_div"}, int'(note_div), 1);
        chk({tag, "_active"}, int'(active), 0);
    endtask

    initial begin
        step(3);
        chk("rst_div", int'(note_div), 1);
        chk("rst_active", int'(active), 0);
        chk("rst_id", int'(cur_id), 0);
        chk("rst_drop", int'(drop_cnt), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            step(1);
            chk("quiet_div", int'(note_div), 1);
            chk("quiet_active", int'(active), 0);
            chk("quiet_drop", int'(drop_cnt), 0);
        end

        jump_tgl = ~jump_tgl;
        step(3);
        chk("jump_latency", int'(note_div), 1);
        play("jump_c4", C4, 21);
        play("jump_e4", E4, 21);
        idle_end("jump_end");
        chk("jump_id", int'(cur_id), 0);

        cd_code = 3'd2; cd_tgl = ~cd_tgl;
        step(3);
        play("cd2_d4", D4, 31);
        idle_end("cd2_end");
        chk("cd2_id", int'(cur_id), 2);
        cd_code = 3'd0; cd_tgl = ~cd_tgl;
        step(3);
        play("cd0_b4", B4, 61);
        idle_end("cd0_end");
        cd_code = 3'd5; cd_tgl = ~cd_tgl;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("cd5_div", int'(note_div), 1);
            chk("cd5_active", int'(active), 0);
        end
        chk("cd5_drop", int'(drop_cnt), 0);
        chk("cd5_id", int'(cur_id), 2);

        over_tgl = ~over_tgl;
        step(3);
        play("over_b4a", B4, 10);
        land_tgl = ~land_tgl;
        play("over_b4b", B4, 21);
        play("over_a4", A4, 31);
        play("over_e4", E4, 31);
        play("over_c4", C4, 61);
        idle_end("over_end");
        chk("over_drop", int'(drop_cnt), 1);
        chk("over_id", int'(cur_id), 3);

        over_tgl = ~over_tgl;
        step(3);
        play("mute_pre", B4, 10);
        mute = 1'b1;
        play("mute_on", 1, 144);
        idle_end("mute_end");
        mute = 1'b0;

        jump_tgl = ~jump_tgl;
        step(3);
        play("rs_jump", C4, 8);
        land_tgl = ~land_tgl;
        play("rs_old", C4, 3);
        play("rs_land", A4, 21);
        idle_end("rs_end");
        chk("rs_id", int'(cur_id), 1);
        chk("rs_drop", int'(drop_cnt), 1);

        land_tgl = ~land_tgl;
        step(3);
        play("prerst_a4", A4, 5);
        #2;
        rst_n = 1'b0;
        jump_tgl = 1'b0; land_tgl = 1'b0; cd_tgl = 1'b0; over_tgl = 1'b0;
        #1;
        chk("arst_div", int'(note_div), 1);
        chk("arst_active", int'(active), 0);
        chk("arst_id", int'(cur_id), 0);
        chk("arst_drop", int'(drop_cnt), 0);
        step(2);
        rst_n = 1'b1;
        step(2);

        jump_tgl = ~jump_tgl; land_tgl = ~land_tgl;
        step(3);
        chk("sim_latency", int'(note_div), 1);
        step(1);
        chk("sim_a4", int'(note_div), A4);
        chk("sim_id", int'(cur_id), 1);
        chk("sim_drop", int'(drop_cnt), 1);
        play("sim_a4_run", A4, 20);
        idle_end("sim_end");

        cd_code = 3'd3;
        jump_tgl = ~jump_tgl; land_tgl = ~land_tgl; cd_tgl = ~cd_tgl; over_tgl = ~over_tgl;
        step(4);
        chk("all_drop", int'(drop_cnt), 4);
        chk("all_id", int'(cur_id), 3);
        chk("all_div", int'(note_div), B4);
        for (int i = 0; i < 99; i++) begin
            jump_tgl = ~jump_tgl; land_tgl = ~land_tgl; cd_tgl = ~cd_tgl; over_tgl = ~over_tgl;
            step(2);
        end
        step(4);
        chk("sat_drop", int'(drop_cnt), 255);
        chk("sat_active", int'(active), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
